instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  RV32I instruction encoder and program-stream generator: the inverse of the
//  main decoder. Accepts a format class plus opcode, funct and register fields
//  and an immediate, and packs them into a 32-bit machine word. Encoded words
//  are queued with their target byte address in a FIFO and streamed out to the
//  instruction-memory loader.
// PARAMETERS
//  DEPTH      4            FIFO entries; must be a power of 2, >= 2
//  ADDR_W     32           width of the word address counter and out_addr
//  BASE_ADDR  32'h0        first byte address; also the value after flush
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  flush      in   1       clears FIFO, sets address counter to BASE_ADDR
//  in_valid   in   1       request valid
//  in_ready   out  1       encoder can accept a request
//  fmt        in   3       000 I, 001 S, 010 B, 011 J, 100 U, 101 R (ImmSrc code)
//  opcode     in   7       instr[6:0]
//  funct3     in   3       instr[14:12]
//  funct7     in   7       instr[31:25], R format only
//  rd         in   5       destination register
//  rs1        in   5       source register 1
//  rs2        in   5       source register 2
//  imm        in   32      immediate, byte offset; U uses imm[31:12]
//  out_valid  out  1       FIFO head valid
//  out_ready  in   1       consumer accepts head
//  out_instr  out  32      encoded word at FIFO head
//  out_addr   out  ADDR_W  byte address of out_instr
//  err        out  1       one-cycle pulse: request rejected
//  err_cnt    out  8       count of rejected requests, saturates at 8'hFF
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, err=0, err_cnt=0, FIFO empty,
//   address counter=BASE_ADDR. All outputs are registered or decoded from
//   registered state. out_instr/out_addr read 0 when the FIFO is empty.
//  Encoding is combinational on the inputs and written into the FIFO in the
//   accept cycle:
//   R {funct7,rs2,rs1,funct3,rd,opcode}
//   I {imm[11:0],rs1,funct3,rd,opcode}
//   S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//   B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
//   U {imm[31:12],rd,opcode}
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
//   Immediate bits outside a format's field are ignored; no range check.
//  Accept: in_valid && in_ready. in_ready = (count != DEPTH); there is no
//   pass-through when full, even if a pop occurs in the same cycle.
//  Reject: an accepted request with fmt 110/111, or with fmt B/J and imm[0]=1.
//   A rejected request is consumed (handshake completes) but is not pushed,
//   and the address counter does not advance. In the next cycle err=1 and
//   err_cnt increments by 1, saturating at 8'hFF.
//  Push: a legal accepted request writes {word, addr} to the FIFO, then the
//   address counter advances by 4. The counter wraps modulo 2^ADDR_W.
//  Latency: a word accepted in cycle N is visible at the head (out_valid=1)
//   in cycle N+1 if the FIFO was empty.
//  Pop: out_valid && out_ready. A push and a pop in the same cycle leave count
//   unchanged. Order is strictly FIFO, and out_instr/out_addr hold stable
//   while out_valid && !out_ready.
//  Flush takes priority over push and pop in the same cycle: FIFO emptied,
//   counter=BASE_ADDR, the request in that cycle is dropped with no err.
//   err_cnt is kept.
//  Reset mid-stream has the same effect as flush, and also clears err_cnt
//   and err.
// TESTING
//  addi x1,x0,5 (I, op 13, f3 0, rd 1, imm 5) -> out_instr 32'h00500093,
//   out_addr BASE_ADDR, out_valid in the cycle after accept.
//  lui x5,0x12345 (U, imm 32'h12345000) then add x3,x1,x2 (R)
//   -> 32'h123452B7 @BASE, then 32'h002081B3 @BASE+4.
//  sw x2,8(x1) -> 32'h0020A423; jal x1,8 -> 32'h008000EF.
//  Hold out_ready=0 and push DEPTH words -> in_ready=0 with 1 extra pending
//   request; release out_ready -> order preserved, no loss or duplication.
//  B fmt with imm=3, then fmt 111 -> two err pulses, err_cnt=2, no FIFO
//   entries, counter unchanged.
//  Assert flush with 2 entries queued plus a simultaneous push -> FIFO empty,
//   the next push appears at BASE_ADDR. Reset with ADDR_W=4 and 5 pushes
//   -> the fifth word's addr wraps to 0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder feeding an address-tagged output FIFO
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [31:0]       instr_mem_q [DEPTH];
    logic [31:0]       instr_mem_d [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d  [DEPTH];

    logic [31:0] instr_word;
    logic        illegal;
    logic        accept;
    logic        push;
    logic        pop;
    logic        reject;

    // Field packing per format; B/J targets must be halfword aligned.
    always_comb begin
        instr_word = '0;
        illegal    = 1'b0;
        case (fmt)
            FMT_I: instr_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: begin
                instr_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal    = imm[0];
            end
            FMT_J: begin
                instr_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal    = imm[0];
            end
            FMT_U: instr_word = {imm[31:12], rd, opcode};
            FMT_R: instr_word = {funct7, rs2, rs1, funct3, rd, opcode};
            default: illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal && !flush;
    assign reject    = accept && illegal && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_d      = addr_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            addr_d   = BASE_ADDR;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = instr_word;
                addr_mem_d[wr_ptr_q]  = addr_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                addr_d                = addr_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            err_d = reject;
            if (reject && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        addr_mem_q  <= addr_mem_d;
    end

    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a queue model
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, out_valid, err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_cnt;

    logic        w_in_ready, w_out_valid, w_err;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;
    logic [7:0]  w_err_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(4'h0)) dut_w4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_addr(w_out_addr), .err(w_err), .err_cnt(w_err_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_instr[$];
    logic [31:0] m_addr[$];
    logic [31:0] m_next;
    logic        m_err;
    int          m_err_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] d, input logic [4:0] s1,
                                              input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] base_bits, w;
        base_bits = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        case (f)
            3'd0: w = base_bits | (32'(d) << 7) | ((im & 32'hFFF) << 20);
            3'd1: w = base_bits | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
            3'd2: w = base_bits | (32'(s2) << 20) | (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
                      | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
            3'd3: w = 32'(op) | (32'(d) << 7) | (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12);
            3'd4: w = 32'(op) | (32'(d) << 7) | (im & 32'hFFFF_F000);
            default: w = base_bits | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_instr.delete();
        m_addr.delete();
        m_next    = BASE;
        m_err     = 1'b0;
        m_err_cnt = 0;
    endtask

    // Compare outputs against the model, advance the model, then clock once.
    task automatic step();
        logic [31:0] ei, ea;
        bit          acc, ill, pp;
        ei = (m_instr.size() != 0) ? m_instr[0] : 32'h0;
        ea = (m_addr.size() != 0)  ? m_addr[0]  : 32'h0;
        check("in_ready",  in_ready,  m_instr.size() != DEPTH);
        check("out_valid", out_valid, m_instr.size() != 0);
        check("out_instr", out_instr, ei);
        check("out_addr",  out_addr,  ea);
        check("err",       err,       m_err);
        check("err_cnt",   err_cnt,   m_err_cnt);
        check("w4_out_instr", w_out_instr, ei);
        check("w4_out_addr",  w_out_addr,  ea[3:0]);
        if (reset) begin
            model_reset();
        end else if (flush) begin
            m_instr.delete();
            m_addr.delete();
            m_next = BASE;
            m_err  = 1'b0;
        end else begin
            acc = in_valid && (m_instr.size() != DEPTH);
            pp  = (m_instr.size() != 0) && out_ready;
            ill = (fmt > 3'd5) || ((fmt == 3'd2 || fmt == 3'd3) && imm[0]);
            if (pp) begin
                void'(m_instr.pop_front());
                void'(m_addr.pop_front());
            end
            if (acc && !ill) begin
                m_instr.push_back(model_enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm));
                m_addr.push_back(m_next);
                m_next = m_next + 32'd4;
            end
            m_err = acc && ill;
            if (m_err && m_err_cnt < 255) m_err_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        set_req(f, op, f3, f7, d, s1, s2, im);
        step();
        in_valid = 1'b0;
    endtask

    task automatic rand_req(input bit legal_only);
        set_req(legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7)),
                7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), legal_only ? ($urandom & 32'hFFFF_FFFE) : $urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        step();

        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("addi_word", out_instr, 32'h0050_0093);
        check("addi_addr", out_addr, BASE);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        send(3'd5, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        check("lui_word", out_instr, 32'h1234_52B7);
        check("lui_addr", out_addr, BASE + 32'd4);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("add_word", out_instr, 32'h0020_81B3);
        check("add_addr", out_addr, BASE + 32'd8);
        out_ready = 1'b1; step();

        send(3'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        check("sw_word", out_instr, 32'h0020_A423);
        send(3'd3, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        check("jal_word", out_instr, 32'h0080_00EF);
        step();

        out_ready = 1'b0;
        repeat (DEPTH + 1) begin
            rand_req(1'b1);
            step();
        end
        check("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (DEPTH + 2) step();

        do_reset();
        send(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        step();
        check("err_cnt_two", err_cnt, 8'd2);
        check("err_no_entry", out_valid, 1'b0);

        out_ready = 1'b0;
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        check("err_addr_kept", out_addr, BASE);
        flush = 1'b1;
        rand_req(1'b1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("flush_base", out_addr, BASE);
        check("flush_err_cnt", err_cnt, 8'd2);
        out_ready = 1'b1;
        step();

        do_reset();
        repeat (5) send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        check("w4_wrap", w_out_addr, 4'h0);
        step();

        set_req(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        repeat (260) step();
        in_valid = 1'b0;
        step();
        check("err_sat", err_cnt, 8'hFF);

        repeat (600) begin
            if ($urandom_range(0, 3) != 0) rand_req(1'b0);
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
